// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, issue and start/run/halt control for a small instruction memory
module fetch_controller #(
    parameter int ADDR_W   = 4,
    parameter int PROG_LEN = 6,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic [31:0]       instruction_in,
    output logic [ADDR_W-1:0] instruction_addr,
    output logic [31:0]       instruction_out,
    output logic              instr_valid,
    output logic              busy,
    output logic              halted,
    output logic              bad_target,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LEN_W   = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               bad_n;
    logic [ADDR_W:0]    target;

    // Target is formed one bit wider than the PC so negative results and
    // overflow past the top of memory both land outside 0..PROG_LEN-1.
    assign target = {1'b0, pc} + (ADDR_W+1)'(1) + branch_offset[ADDR_W:0];

    assign instr_valid      = (state == RUN) && !stall && !halt_req;
    assign instruction_out  = instr_valid ? instruction_in : 32'b0;
    assign instruction_addr = pc;
    assign busy             = (state == RUN);
    assign halted           = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= '0;
            retired_count <= '0;
            bad_target    <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            retired_count <= cnt_n;
            bad_target    <= bad_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = retired_count;
        bad_n   = bad_target;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = '0;
                    cnt_n   = '0;
                    bad_n   = 1'b0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_n = HALT;
                end else if (!stall) begin
                    if (retired_count != '1)
                        cnt_n = retired_count + CNT_W'(1);
                    if (branch_taken) begin
                        if (target < LEN_W) begin
                            pc_n = target[ADDR_W-1:0];
                        end else begin
                            bad_n   = 1'b1;
                            state_n = HALT;
                        end
                    end else if (pc == LAST_PC) begin
                        state_n = HALT;
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - table-driven self-checking bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, halt_req, branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] instruction_in;
    logic [3:0]  instruction_addr;
    logic [31:0] instruction_out;
    logic        instr_valid, busy, halted, bad_target;
    logic [7:0]  retired_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word i holds A000_0000 + i.
    assign instruction_in = 32'hA000_0000 + {28'b0, instruction_addr};

    fetch_controller #(.ADDR_W(4), .PROG_LEN(6), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .instruction_in(instruction_in), .instruction_addr(instruction_addr),
        .instruction_out(instruction_out), .instr_valid(instr_valid), .busy(busy),
        .halted(halted), .bad_target(bad_target), .retired_count(retired_count)
    );

    typedef struct {
        logic        st, sl, hr, br;
        logic [15:0] off;
        logic [3:0]  addr;
        logic        valid, bsy, hlt, bad;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, input logic v, input logic b,
                           input logic h, input logic bd, input logic [7:0] c);
        chk({tag, " addr"}, 32'(instruction_addr), 32'(a));
        chk({tag, " valid"}, 32'(instr_valid), 32'(v));
        chk({tag, " instr"}, instruction_out, v ? 32'hA000_0000 + 32'(a) : 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " halted"}, 32'(halted), 32'(h));
        chk({tag, " bad"}, 32'(bad_target), 32'(bd));
        chk({tag, " count"}, 32'(retired_count), 32'(c));
    endtask

    task automatic drive(input logic s, input logic sl, input logic hr, input logic br, input logic [15:0] off);
        start = s; stall = sl; halt_req = hr; branch_taken = br; branch_offset = off;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic sl, input logic hr, input logic br, input logic [15:0] off,
                       input logic [3:0] a, input logic v, input logic b, input logic h, input logic bd,
                       input logic [7:0] c);
        vec_t t;
        t.st = s; t.sl = sl; t.hr = hr; t.br = br; t.off = off;
        t.addr = a; t.valid = v; t.bsy = b; t.hlt = h; t.bad = bd; t.cnt = c;
        vecs.push_back(t);
    endtask

    initial begin
        // straight-line program
        add(0,0,0,0,16'h0,   0,0,0,0,0,0);
        add(1,0,0,0,16'h0,   0,0,0,0,0,0);
        add(0,0,0,0,16'h0,   0,1,1,0,0,0);
        add(0,0,0,0,16'h0,   1,1,1,0,0,1);
        add(0,0,0,0,16'h0,   2,1,1,0,0,2);
        add(0,0,0,0,16'h0,   3,1,1,0,0,3);
        add(0,0,0,0,16'h0,   4,1,1,0,0,4);
        add(0,0,0,0,16'h0,   5,1,1,0,0,5);
        // forward branch at PC=2 skips 3
        add(1,0,0,0,16'h0,   5,0,0,1,0,6);
        add(0,0,0,0,16'h0,   0,1,1,0,0,0);
        add(0,0,0,0,16'h0,   1,1,1,0,0,1);
        add(0,0,0,1,16'h1,   2,1,1,0,0,2);
        add(0,0,0,0,16'h0,   4,1,1,0,0,3);
        add(0,0,0,0,16'h0,   5,1,1,0,0,4);
        // stall at PC=3, branch ignored while stalled
        add(1,0,0,0,16'h0,   5,0,0,1,0,5);
        add(0,0,0,0,16'h0,   0,1,1,0,0,0);
        add(0,0,0,0,16'h0,   1,1,1,0,0,1);
        add(0,0,0,0,16'h0,   2,1,1,0,0,2);
        add(0,1,0,0,16'h0,   3,0,1,0,0,3);
        add(0,1,0,1,16'h1,   3,0,1,0,0,3);
        add(0,1,0,0,16'h0,   3,0,1,0,0,3);
        add(0,0,0,0,16'h0,   3,1,1,0,0,3);
        add(0,0,0,0,16'h0,   4,1,1,0,0,4);
        add(0,0,0,0,16'h0,   5,1,1,0,0,5);
        // out-of-range branch at PC=4 (target 10)
        add(1,0,0,0,16'h0,   5,0,0,1,0,6);
        add(0,0,0,0,16'h0,   0,1,1,0,0,0);
        add(0,0,0,0,16'h0,   1,1,1,0,0,1);
        add(0,0,0,0,16'h0,   2,1,1,0,0,2);
        add(0,0,0,0,16'h0,   3,1,1,0,0,3);
        add(0,0,0,1,16'h5,   4,1,1,0,0,4);
        add(1,0,0,0,16'h0,   4,0,0,1,1,5);
        // restart clears bad_target, then self-loop at PC=1 until halt_req
        add(0,0,0,0,16'h0,   0,1,1,0,0,0);
        add(0,0,0,1,16'hFFFF,1,1,1,0,0,1);
        add(0,0,0,1,16'hFFFF,1,1,1,0,0,2);
        add(0,0,0,1,16'hFFFF,1,1,1,0,0,3);
        add(0,0,0,1,16'hFFFF,1,1,1,0,0,4);
        add(0,1,1,1,16'hFFFF,1,0,1,0,0,5);
        add(0,0,1,0,16'h0,   1,0,0,1,0,5);
        add(1,0,1,0,16'h0,   1,0,0,1,0,5);
        // negative target (-1) is out of range
        add(0,0,0,1,16'hFFFE,0,1,1,0,0,0);
        add(1,0,0,0,16'h0,   0,0,0,1,1,1);
        // branch straight to last word, start during RUN ignored
        add(0,0,0,1,16'h4,   0,1,1,0,0,0);
        add(1,0,0,0,16'h0,   5,1,1,0,0,1);
        add(0,0,0,0,16'h0,   5,0,0,1,0,2);

        drive(0,0,0,0,16'h0);
        rst = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sl, vecs[i].hr, vecs[i].br, vecs[i].off);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].bsy,
                    vecs[i].hlt, vecs[i].bad, vecs[i].cnt);
            step();
        end

        // counter saturation in a long self-loop
        drive(1,0,0,0,16'h0); step();
        drive(0,0,0,0,16'h0); step();
        drive(0,0,0,1,16'hFFFF);
        for (int k = 0; k < 260; k++) step();
        chk_all("saturate", 1, 1, 1, 0, 0, 8'hFF);
        drive(0,0,1,0,16'h0); step();
        drive(0,0,0,0,16'h0);
        chk_all("sat_halt", 1, 0, 0, 1, 0, 8'hFF);

        // asynchronous reset mid-RUN at PC=3
        drive(1,0,0,0,16'h0); step();
        drive(0,0,0,0,16'h0);
        step(); step(); step();
        chk_all("pre_rst", 3, 1, 1, 0, 0, 3);
        #3 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("rst_held", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);
        drive(1,0,0,0,16'h0); step();
        drive(0,0,0,0,16'h0);
        chk_all("restart0", 0, 1, 1, 0, 0, 0);
        step();
        chk_all("restart1", 1, 1, 1, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequencing controller for the 16-entry, word-addressed, combinationally read instruction memory. Owns the program counter, drives instruction_addr and issues one instruction per cycle to the single-cycle datapath. Applies branch redirects from the datapath, stalls and halts, and runs a start/run/halt state machine with a retired-instruction counter.

Parameters:
ADDR_W, 4, instruction address width (memory depth 2**ADDR_W words)
PROG_LEN, 6, number of valid program words; address PROG_LEN-1 is the last instruction
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  pulse: begin execution at address 0 (accepted in IDLE or HALT only)
stall  input  1  datapath stall; holds PC, suppresses issue
halt_req  input  1  external stop request
branch_taken  input  1  datapath branch decision for the instruction issued this cycle
branch_offset  input  16  signed word offset of the issued branch (immediate field)
instruction_in  input  32  read data from instruction memory
instruction_addr  output  ADDR_W  current PC to instruction memory
instruction_out  output  32  instruction presented to datapath (instruction_in when issuing, else 0)
instr_valid  output  1  instruction_out is issued and retires this cycle
busy  output  1  high in RUN
halted  output  1  high in HALT
bad_target  output  1  sticky: a branch target fell outside 0..PROG_LEN-1
retired_count  output  CNT_W  instructions retired since last start

Behaviour:
- Reset (rst low, asynchronous): state IDLE; PC=0; instr_valid=0; busy=0; halted=0; bad_target=0; retired_count=0; instruction_out=0.
- States: IDLE, RUN, HALT. 2-bit encoded state register; all outputs except instruction_out/instr_valid are registered.
- IDLE: PC held at 0. start=1 -> RUN next cycle.
- RUN:
  - Issue: instr_valid = !stall && !halt_req (combinational). instruction_out = instruction_in when instr_valid, else 32'b0.
  - Retire: each cycle with instr_valid=1 increments retired_count by 1; saturates at all-ones.
- Next PC in RUN when instr_valid=1:
  - branch_taken=1: target = PC + 1 + branch_offset, computed at ADDR_W+1 bits signed. Offset is sign-truncated to ADDR_W+1 bits.
  - If target lies in 0..PROG_LEN-1: PC <- target, remain RUN.
  - If target is outside that range: set bad_target (sticky), go to HALT, PC unchanged.
  - branch_taken=0 and PC == PROG_LEN-1: go to HALT, PC unchanged. The last instruction still retires.
  - Otherwise PC <- PC + 1.
- stall=1 in RUN: PC, state and counter hold; branch_taken ignored.
- halt_req=1 in RUN: go to HALT next cycle with no issue that cycle. halt_req has priority over stall and branch.
- HALT: halted=1, PC frozen, instr_valid=0.
  - start=1 -> PC<=0, retired_count<=0, bad_target<=0, RUN next cycle.
  - halt_req is ignored.
- start while in RUN is ignored. Simultaneous start and halt_req in IDLE/HALT: start wins.
- Reset asserted mid-RUN aborts immediately. No instruction is marked valid during or after reset until a new start.
- Branch to self (offset -1) is legal and loops until halt_req.
- No wrap-around of PC past 2**ADDR_W-1: the range check covers it.

Test Plan:
- Reset then start, no branches, PROG_LEN=6 -> addresses 0,1,2,3,4,5 each with instr_valid=1; halted=1 on the cycle after addr 5; retired_count=6; bad_target=0.
- start; branch_taken=1, offset=1 when PC=2 -> address sequence 0,1,2,4,5, then HALT with retired_count=5.
- stall high for 3 cycles while PC=3 -> instruction_addr stays 3, instr_valid=0 for 3 cycles, retired_count unchanged; then resumes 3,4,5.
- Branch at PC=4 with offset=+5 (target 10 >= PROG_LEN) -> bad_target=1, halted=1, PC=4, retired_count=5. Then start -> bad_target cleared, PC=0, RUN.
- Branch offset=-1 at PC=1 (self-loop) for 4 cycles, then halt_req -> addr 1 repeated, retired_count increments each cycle, HALT with no issue in the halt_req cycle.
- rst driven low asynchronously mid-RUN at PC=3 -> all outputs at reset values immediately without a clock edge; start after release -> fetch resumes from address 0.
